c16_muldiv: RTL
===============

# c16_muldiv

Parametrised iterative multiply/divide execution unit for the c16 core family. It fills the core's multiply and divide execute states, which currently complete with no result. The core launches an operation with a one-cycle start, stalls on busy, and writes result to the destination register on done. Operand width is a parameter so the same unit serves the 16-bit core and wider successors. It supports signed and unsigned operation, high/low product halves, and quotient/remainder.

## Interface
- WIDTH, default 16: operand and result width; legal range 4 to 64.
- clk  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  operation: MUL_LO=0, MUL_HI=1, DIV=2, REM=3.
- sgn  in  1  1 = two's-complement operands, 0 = unsigned.
- a  in  WIDTH  multiplicand or dividend.
- b  in  WIDTH  multiplier or divisor.
- busy  out  1  operation in progress; start is ignored while high.
- done  out  1  one-cycle pulse; result is valid from this cycle onward.
- result  out  WIDTH  last result; held until the next done.
- div_zero  out  1  set with done when DIV/REM had b=0; cleared on the next start.

## Operation
- Reset values: busy=0, done=0, result=0, div_zero=0, state=IDLE. Reset mid-operation aborts the operation; no done pulse follows.
- States:
  - IDLE: on start, latch a, b, op and sgn, clear div_zero, go to PREP.
  - PREP: compute operand magnitudes (absolute values if sgn=1) and the result sign. Load the iteration counter with WIDTH-1, then go to ITER. Go directly to FIX instead if this is DIV/REM with b=0.
  - ITER: radix-2 step, one per cycle, WIDTH cycles, then go to FIX.
    - Multiply: shift-add into a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract, producing quotient and partial remainder.
  - FIX: apply sign correction and select the output. Set result and done=1, busy=0, then go to IDLE.
- Signed rules:
  - The product is negated when the operand signs differ.
  - The quotient truncates toward zero.
  - The remainder takes the sign of the dividend.
  - MIN / -1 gives quotient MIN and remainder 0, with no flag.
- Divide by zero: quotient is all-ones, remainder is a, div_zero=1.
- Widths:
  - MUL_LO returns product[WIDTH-1:0]; MUL_HI returns product[2·WIDTH-1:WIDTH].
  - Absolute value of MIN is taken as the unsigned magnitude 2^(WIDTH-1).
- start asserted while busy, or in the cycle done is high, is ignored. The core must re-assert start after done.

## Timing
- start sampled high at edge n:
  - busy=1 from edge n to edge n+WIDTH+2.
  - done=1 for exactly one cycle, from edge n+WIDTH+2.
- Divide by zero: done from edge n+2.
- Fixed latency, not data-dependent, apart from the divide-by-zero fast path.
- Back-to-back operation: the earliest next start is sampled at edge n+WIDTH+3.

## Configuration
- C16_MULDIV_DIV_EN defined: DIV and REM are implemented as specified above.
- Undefined: the divider datapath is removed.
  - DIV/REM skip PREP iterations and complete with done from edge n+2.
  - They return result=0 and div_zero=0.
  - MUL timing is unchanged.

## Structure
- Shared package c16_pkg holds:
  - the op encodings MUL_LO, MUL_HI, DIV, REM;
  - the state enum (IDLE, PREP, ITER, FIX);
  - the WIDTH legality constants.
- Single module. No sub-module is warranted: multiply and divide share the accumulator and the counter.

## Test plan
- Unsigned MUL_LO and MUL_HI, WIDTH=16, a=0x1234, b=0x0056: results 0x1D78 and 0x0006. done arrives exactly 18 cycles after start, and busy is high throughout.
- Signed MUL_LO and MUL_HI, a=0xFFFD (-3), b=0x0005: results 0xFFF1 and 0xFFFF.
- Signed DIV and REM, a=0xFFF9 (-7), b=0x0002: results 0xFFFD and 0xFFFF. Signed DIV, a=0x8000, b=0xFFFF: result 0x8000, div_zero=0.
- DIV, a=0x1234, b=0: result 0xFFFF, div_zero=1, done at edge n+2. REM with the same operands: result 0x1234.
- Second start pulsed at edge n+5 of a running MUL: ignored, and the first result is unchanged. resetn dropped at edge n+8: busy, done and result go to 0 immediately, and no done pulse follows.
- Build without C16_MULDIV_DIV_EN: DIV 100/7 returns result 0, done at edge n+2, div_zero=0. MUL 7×9 returns 63.

Source files
------------

// File: rtl/c16_pkg.sv
// Shared definitions for the c16 multiply/divide unit: op encodings, the
// sequencer state type and the supported operand-width range.
package c16_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 64;

  localparam logic [1:0] MUL_LO = 2'd0;
  localparam logic [1:0] MUL_HI = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] REM    = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } state_e;

endpackage

// File: rtl/c16_muldiv.sv
// Iterative radix-2 multiply/divide unit with signed/unsigned operands.
// Define C16_MULDIV_DIV_EN to build the divider; otherwise DIV/REM return 0 quickly.
//
// state | meaning
// IDLE  | waiting for start; operands latched on start
// PREP  | form operand magnitudes and result sign, load counter
// ITER  | one shift-add or shift-subtract step per cycle, WIDTH steps
// FIX   | sign-correct, select result, pulse done
module c16_muldiv
  import c16_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("c16_muldiv: WIDTH outside supported range");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic               sgn_q, sgn_d, neg_q, neg_d;
  logic               busy_q, busy_d, done_q, done_d, dz_q, dz_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, m_q, m_d, result_q, result_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               is_div;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

  assign is_div  = op_q[1];
  // -MIN wraps to MIN, which read unsigned is exactly the 2^(WIDTH-1) magnitude
  assign a_mag   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
  assign b_mag   = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
  assign prod    = neg_q ? -acc_q : acc_q;

`ifdef C16_MULDIV_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_diff, div_mag, div_res;
  logic             rem_ge;

  // acc holds {partial remainder, dividend/quotient}; the difference fits WIDTH bits when rem_ge
  assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
  assign rem_ge   = (rem_sh >= {1'b0, m_q});
  assign rem_diff = rem_sh[WIDTH-1:0] - m_q;
  assign div_mag  = op_q[0] ? acc_q[2*WIDTH-1:WIDTH] : acc_q[WIDTH-1:0];
  assign div_res  = neg_q ? -div_mag : div_mag;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sgn_d    = sgn_q;
    neg_d    = neg_q;
    a_d      = a_q;
    b_d      = b_q;
    m_d      = m_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    dz_d     = dz_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          sgn_d   = sgn;
          a_d     = a;
          b_d     = b;
          dz_d    = 1'b0;
          busy_d  = 1'b1;
          state_d = PREP;
        end
      end
      PREP: begin
        cnt_d = CW'(WIDTH - 1);
        neg_d = sgn_q & ((op_q == REM) ? a_q[WIDTH-1] : (a_q[WIDTH-1] ^ b_q[WIDTH-1]));
        if (is_div) begin
`ifdef C16_MULDIV_DIV_EN
          acc_d   = {{WIDTH{1'b0}}, a_mag};
          m_d     = b_mag;
          state_d = (b_q == '0) ? FIX : ITER;
`else
          state_d = FIX;
`endif
        end else begin
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          m_d     = a_mag;
          state_d = ITER;
        end
      end
      ITER: begin
`ifdef C16_MULDIV_DIV_EN
        if (is_div) begin
          acc_d = {(rem_ge ? rem_diff : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], rem_ge};
        end else begin
          acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        end
`else
        acc_d = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
`endif
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      FIX: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (!is_div) begin
          result_d = op_q[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        end else begin
`ifdef C16_MULDIV_DIV_EN
          if (b_q == '0) begin
            result_d = op_q[0] ? a_q : '1;
            dz_d     = 1'b1;
          end else begin
            result_d = div_res;
          end
`else
          result_d = '0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      op_q     <= 2'd0;
      sgn_q    <= 1'b0;
      neg_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sgn_q    <= sgn_d;
      neg_q    <= neg_d;
      a_q      <= a_d;
      b_q      <= b_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
      result_q <= result_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign div_zero = dz_q;

endmodule
